wb_cpu_master: RTL and testbench

Wishbone classic single-cycle bus master that turns CPU-side fetch/load/store requests into Wishbone B3 classic read/write cycles. It sits between the core's instruction-fetch or load-store stage and the Wishbone interconnect that hosts the instruction ROM, UART and GPIO slaves. It registers all bus outputs, supports pipeline flush mid-cycle, and optionally enforces a bus timeout.

---
 rtl/wb_cpu_master.sv | 180 ++++++++++++++++++
 tb/tb_wb_cpu_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cpu_master.sv
// wb_cpu_master -- Wishbone B3 classic single-cycle bus master.
//
// Converts CPU fetch/load/store requests into Wishbone classic read/write
// cycles. Every output is a register; nothing passes combinationally from an
// input to an output.
//
// Parameters:
//   AW      address width
//   DW      data width
//   TIMEOUT strobe cycles without ack before the cycle is aborted
//           (used only when WB_MASTER_TIMEOUT_EN is defined)
//
// Optional feature macro:
//   WB_MASTER_TIMEOUT_EN  when defined, a 16-bit counter aborts a stalled
//                         cycle with cpu_ack_o + cpu_err_o. When undefined,
//                         the master waits forever and cpu_err_o is tied 0.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock (rising edge), synchronous active-low reset
//   cpu_req_i/we/addr/data/sel CPU request; sampled only in IDLE
//   cpu_flush_i               drop the in-flight request, no ack
//   cpu_data_o/ack_o/err_o    completion: one-cycle ack (+err on timeout)
//   cpu_stall_o               request accepted but not yet completed
//   wb_adr_o/dat_o/sel_o/we_o/stb_o/cyc_o, wb_dat_i, wb_ack_i  Wishbone side
module wb_cpu_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_data_i,
    input  logic [3:0]    cpu_sel_i,
    input  logic          cpu_flush_i,
    output logic [DW-1:0] cpu_data_o,
    output logic          cpu_ack_o,
    output logic          cpu_err_o,
    output logic          cpu_stall_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_stb_o,
    output logic          wb_cyc_o,
    input  logic          wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          cyc_d;
    logic          we_d;
    logic [AW-1:0] adr_d;
    logic [DW-1:0] dat_d;
    logic [3:0]    sel_d;
    logic          ack_d;
    logic [DW-1:0] rdata_d;
    logic          stall_d;

`ifdef WB_MASTER_TIMEOUT_EN
    logic [15:0]   tmo_cnt, tmo_cnt_d;
    logic          err_d;
`endif

    // Next-state and next-output logic; every register has its next value
    // computed here so the outputs stay purely registered.
    always_comb begin
        state_d = state_q;
        cyc_d   = wb_cyc_o;
        we_d    = wb_we_o;
        adr_d   = wb_adr_o;
        dat_d   = wb_dat_o;
        sel_d   = wb_sel_o;
        ack_d   = 1'b0;
        rdata_d = '0;
        stall_d = cpu_stall_o;
`ifdef WB_MASTER_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt;
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // A flush in IDLE blocks acceptance for that cycle.
                if (cpu_req_i && !cpu_flush_i) begin
                    adr_d   = cpu_addr_i;
                    dat_d   = cpu_data_i;
                    sel_d   = cpu_sel_i;
                    we_d    = cpu_we_i;
                    cyc_d   = 1'b1;
                    stall_d = 1'b1;
                    state_d = BUS;
`ifdef WB_MASTER_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            BUS: begin
                // Flush beats a coincident ack; the ack is discarded.
                if (cpu_flush_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    stall_d = 1'b0;
                    state_d = GAP;
                end else if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    ack_d   = 1'b1;
                    rdata_d = wb_we_o ? '0 : wb_dat_i;
                    stall_d = 1'b0;
                    state_d = GAP;
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    stall_d = 1'b0;
                    state_d = GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt + 16'd1;
                end
`endif
            end
            // One dead cycle so a slave that holds its registered ack one
            // cycle too long cannot complete the next request.
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q     <= IDLE;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= 4'h0;
            cpu_ack_o   <= 1'b0;
            cpu_data_o  <= '0;
            cpu_stall_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_cyc_o    <= cyc_d;
            wb_stb_o    <= cyc_d;
            wb_we_o     <= we_d;
            wb_adr_o    <= adr_d;
            wb_dat_o    <= dat_d;
            wb_sel_o    <= sel_d;
            cpu_ack_o   <= ack_d;
            cpu_data_o  <= rdata_d;
            cpu_stall_o <= stall_d;
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            tmo_cnt   <= '0;
            cpu_err_o <= 1'b0;
        end else begin
            tmo_cnt   <= tmo_cnt_d;
            cpu_err_o <= err_d;
        end
    end
`else
    assign cpu_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_cpu_master.sv
// Directed self-checking bench for wb_cpu_master. Inputs are driven and
// outputs sampled on the falling clock edge, one cycle per tick().
// Build with or without WB_MASTER_TIMEOUT_EN; the timeout test adapts.
module tb_wb_cpu_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cpu_req_i, cpu_we_i, cpu_flush_i;
    logic [31:0] cpu_addr_i, cpu_data_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        cpu_ack_o, cpu_err_o, cpu_stall_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;

    int n_chk  = 0;
    int n_fail = 0;
    int ack_cnt = 0;
    int cyc_run;
    int exp_acks;

    wb_cpu_master #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_sel_i(cpu_sel_i), .cpu_flush_i(cpu_flush_i),
        .cpu_data_o(cpu_data_o), .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o),
        .cpu_stall_o(cpu_stall_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Count every cycle in which the completion pulse is high.
    always @(negedge wb_clk_i) if (cpu_ack_o === 1'b1) ack_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge wb_clk_i);
    endtask

    task automatic request(input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] sel);
        cpu_req_i  = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = data;
        cpu_sel_i  = sel;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_rst_i = 1'b0; cpu_flush_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = '0;
        request(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF);

        // Reset held 3 cycles with a live request: nothing leaves the master.
        repeat (3) tick();
        check("rst_cyc",   {31'd0, wb_cyc_o},    32'd0);
        check("rst_stb",   {31'd0, wb_stb_o},    32'd0);
        check("rst_we",    {31'd0, wb_we_o},     32'd0);
        check("rst_ack",   {31'd0, cpu_ack_o},   32'd0);
        check("rst_err",   {31'd0, cpu_err_o},   32'd0);
        check("rst_stall", {31'd0, cpu_stall_o}, 32'd0);
        check("rst_adr",   wb_adr_o,             32'd0);
        check("rst_dat",   wb_dat_o,             32'd0);
        check("rst_sel",   {28'd0, wb_sel_o},    32'd0);
        check("rst_rdata", cpu_data_o,           32'd0);
        cpu_req_i = 1'b0; wb_rst_i = 1'b1;
        tick();

        // Read with 3 wait states.
        request(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        tick();
        check("rd_cyc",   {31'd0, wb_cyc_o},    32'd1);
        check("rd_stb",   {31'd0, wb_stb_o},    32'd1);
        check("rd_we",    {31'd0, wb_we_o},     32'd0);
        check("rd_adr",   wb_adr_o,             32'h10);
        check("rd_stall", {31'd0, cpu_stall_o}, 32'd1);
        cpu_req_i = 1'b0;
        tick(); tick();
        check("rd_wait_cyc", {31'd0, wb_cyc_o},  32'd1);
        check("rd_wait_ack", {31'd0, cpu_ack_o}, 32'd0);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        check("rd_ack",    {31'd0, cpu_ack_o},   32'd1);
        check("rd_data",   cpu_data_o,           32'hDEAD_BEEF);
        check("rd_gap",    {31'd0, wb_cyc_o},    32'd0);
        check("rd_nostall",{31'd0, cpu_stall_o}, 32'd0);
        tick();
        check("rd_ack_1cy", {31'd0, cpu_ack_o}, 32'd0);

        // Write, zero-wait slave; read data bus carries junk that must not leak.
        request(1'b1, 32'h2000_0004, 32'h0000_00A5, 4'b0001);
        tick();
        cpu_req_i = 1'b0;
        check("wr_we",  {31'd0, wb_we_o},  32'd1);
        check("wr_sel", {28'd0, wb_sel_o}, 32'h1);
        check("wr_adr", wb_adr_o,          32'h2000_0004);
        check("wr_dat", wb_dat_o,          32'hA5);
        wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
        tick();
        wb_ack_i = 1'b0;
        check("wr_ack",  {31'd0, cpu_ack_o}, 32'd1);
        check("wr_data", cpu_data_o,         32'd0);
        check("wr_we_clr", {31'd0, wb_we_o}, 32'd0);
        tick();
        check("wr_ack_1cy", {31'd0, cpu_ack_o}, 32'd0);

        // Sticky ack: slave holds ack 2 cycles while a second request waits.
        request(1'b0, 32'h0000_0030, 32'h0, 4'hF);
        tick();
        cpu_addr_i = 32'h0000_0034;
        wb_ack_i = 1'b1; wb_dat_i = 32'h1111_1111;
        tick();
        check("st_ack1",  {31'd0, cpu_ack_o}, 32'd1);
        check("st_data1", cpu_data_o,         32'h1111_1111);
        check("st_gap",   {31'd0, wb_cyc_o},  32'd0);
        wb_dat_i = 32'h2222_2222;
        tick();
        wb_ack_i = 1'b0;
        check("st_idle_cyc", {31'd0, wb_cyc_o},  32'd0);
        check("st_no_ack",   {31'd0, cpu_ack_o}, 32'd0);
        tick();
        cpu_req_i = 1'b0;
        check("st_cyc2", {31'd0, wb_cyc_o}, 32'd1);
        check("st_adr2", wb_adr_o,          32'h34);
        check("st_no_ack2", {31'd0, cpu_ack_o}, 32'd0);
        wb_ack_i = 1'b1; wb_dat_i = 32'h3333_3333;
        tick();
        wb_ack_i = 1'b0;
        check("st_ack2",  {31'd0, cpu_ack_o}, 32'd1);
        check("st_data2", cpu_data_o,         32'h3333_3333);
        tick();

        // Flush coincident with ack: ack discarded, next request normal.
        request(1'b0, 32'h0000_0040, 32'h0, 4'hF);
        tick();
        cpu_req_i = 1'b0;
        wb_ack_i = 1'b1; cpu_flush_i = 1'b1; wb_dat_i = 32'h55;
        tick();
        wb_ack_i = 1'b0; cpu_flush_i = 1'b0;
        check("fl_no_ack", {31'd0, cpu_ack_o},   32'd0);
        check("fl_cyc",    {31'd0, wb_cyc_o},    32'd0);
        check("fl_stall",  {31'd0, cpu_stall_o}, 32'd0);
        tick();
        check("fl_no_ack2", {31'd0, cpu_ack_o}, 32'd0);
        request(1'b0, 32'h0000_0044, 32'h0, 4'hF);
        tick();
        cpu_req_i = 1'b0;
        check("fl_next_cyc", {31'd0, wb_cyc_o}, 32'd1);
        check("fl_next_adr", wb_adr_o,          32'h44);
        wb_ack_i = 1'b1; wb_dat_i = 32'h66;
        tick();
        wb_ack_i = 1'b0;
        check("fl_next_ack",  {31'd0, cpu_ack_o}, 32'd1);
        check("fl_next_data", cpu_data_o,         32'h66);
        tick();

        // Flush in IDLE blocks acceptance for that cycle only.
        request(1'b0, 32'h0000_0048, 32'h0, 4'hF);
        cpu_flush_i = 1'b1;
        tick();
        cpu_flush_i = 1'b0;
        check("fi_blocked", {31'd0, wb_cyc_o}, 32'd0);
        tick();
        cpu_req_i = 1'b0;
        check("fi_accept", {31'd0, wb_cyc_o}, 32'd1);
        wb_ack_i = 1'b1; wb_dat_i = 32'h77;
        tick();
        wb_ack_i = 1'b0;
        check("fi_ack", {31'd0, cpu_ack_o}, 32'd1);
        tick();

        // Slave that never acks.
        request(1'b0, 32'h0000_0050, 32'h0, 4'hF);
        tick();
        cpu_req_i = 1'b0;
        cyc_run = 0;
        for (int i = 0; i < 100; i++) begin
            if (wb_cyc_o !== 1'b1) break;
            cyc_run++;
            tick();
        end
`ifdef WB_MASTER_TIMEOUT_EN
        check("to_cyc_cycles", cyc_run,               32'd16);
        check("to_ack",        {31'd0, cpu_ack_o},    32'd1);
        check("to_err",        {31'd0, cpu_err_o},    32'd1);
        check("to_data",       cpu_data_o,            32'd0);
        tick();
        check("to_ack_1cy",    {31'd0, cpu_ack_o},    32'd0);
        check("to_err_1cy",    {31'd0, cpu_err_o},    32'd0);
        exp_acks = 7;
`else
        check("nto_cyc_cycles", cyc_run,             32'd100);
        check("nto_err",        {31'd0, cpu_err_o},  32'd0);
        cpu_flush_i = 1'b1;
        tick();
        cpu_flush_i = 1'b0;
        check("nto_flush_cyc",  {31'd0, wb_cyc_o},   32'd0);
        check("nto_flush_ack",  {31'd0, cpu_ack_o},  32'd0);
        exp_acks = 6;
`endif
        tick();
        check("ack_total", ack_cnt, exp_acks);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
